dcache_axi_bridge: RTL

DCACHE_AXI_BRIDGE -- requirements
Module: dcache_axi_bridge

---
 rtl/cpu_axi_pkg.sv | 18 +
 rtl/dcache_axi_bridge_flop.sv | 24 ++
 rtl/dcache_axi_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared AXI constants and the dCache bridge state type.
//   BURST_INCR / SIZE_WORD / STRB_ALL : fixed single-beat word transfer attributes
//   bridge_state_e                    : bridge FSM state encoding
package cpu_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [3:0] STRB_ALL   = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAww,
    StB
  } bridge_state_e;

endpackage

// File: rtl/dcache_axi_bridge_flop.sv
// Enable flop cell with asynchronous active-low clear.
//   clk   : clock
//   reset : asynchronous active-low clear (q -> 0)
//   en    : load enable
//   d / q : data in / registered data out
module dcache_axi_bridge_flop #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dcache_axi_bridge.sv
// dCache-to-AXI bridge: converts single-word dCache reads/writes into single-beat
// AXI transactions, one outstanding at a time.
//   clk, reset                      : clock, asynchronous active-low reset
//   mem_req/wen/addr/wdata          : dCache request side
//   mem_addr_ok/data_ok/rdata       : dCache handshake and read data
//   ar*/r*                          : AXI read address / read data channels
//   aw*/w*/b*                       : AXI write address / write data / response channels
module dcache_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, wdata_q;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          data_ok_q, data_ok_d;
  logic          rdata_en;
  logic          aw_fire, w_fire;

  // Responses are never errors here; these inputs only exist for AXI completeness.
  logic unused_inputs;
  assign unused_inputs = ^{mem_addr[1:0], rid, rresp, rlast, bid, bresp};

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arsize  = SIZE_WORD;
  assign awsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign wstrb   = STRB_ALL;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;

  assign mem_data_ok = data_ok_q;

  // AW and W are independent channels; each valid drops once its own beat is taken.
  assign awvalid = (state_q == StAww) & ~aw_done_q;
  assign wvalid  = (state_q == StAww) & ~w_done_q;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    data_ok_d   = 1'b0;
    mem_addr_ok = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    bready      = 1'b0;
    rdata_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_addr_ok = mem_req;
        if (mem_req) state_d = mem_wen ? StAww : StAr;
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) state_d = StR;
      end
      StR: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_en  = 1'b1;
          data_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StAww: begin
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StB;
        end else begin
          aw_done_d = aw_done_q | aw_fire;
          w_done_d  = w_done_q | w_fire;
        end
      end
      StB: begin
        bready = 1'b1;
        if (bvalid) begin
          data_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
      if (mem_req && mem_addr_ok) begin
        addr_q  <= {mem_addr[31:2], 2'b00};
        wdata_q <= mem_wdata;
      end
    end
  end

  dcache_axi_bridge_flop #(
    .Width(32)
  ) u_rdata_flop (
    .clk  (clk),
    .reset(reset),
    .en   (rdata_en),
    .d    (rdata),
    .q    (mem_rdata)
  );

endmodule
